// File: rtl/cascade_timer_ctrl_if.sv
// Nibble-serial load bus for the cascaded timer: one slice value per valid/ready beat,
// least-significant slice first.
interface cascade_timer_ctrl_if #(
    parameter int SLICE_W = 4
);
    logic               ld_valid;
    logic               ld_ready;
    logic [SLICE_W-1:0] ld_data;

    modport master (
        output ld_valid,
        output ld_data,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        output ld_ready
    );
endinterface

// File: rtl/cascade_timer_ctrl.sv
// Sequencing controller for a cascaded down-counter: serial terminal-value load, arm,
// enable-gated run with slice borrow lookahead, terminal-count pulse and optional reload.
module cascade_timer_ctrl #(
    parameter int NSLICE  = 4,
    parameter int SLICE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cascade_timer_ctrl_if.slave        ld_bus,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_auto_reload,
    input  logic                       i_cnt_en,
    output logic [NSLICE*SLICE_W-1:0]  o_count,
    output logic                       o_tc,
    output logic                       o_busy,
    output logic [2:0]                 o_state
);
    localparam int W     = NSLICE * SLICE_W;
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [W-1:0]      r_count, w_count_nxt;
    logic [W-1:0]      r_shadow, w_shadow_nxt, w_shadow_wr;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_wr_idx;
    logic              r_tc, w_tc_nxt;
    logic              w_ready, w_beat, w_last_beat, w_count_zero;
    logic [NSLICE-1:0] w_slice_zero, w_borrow;

    // Decrement every slice whose borrow is set; a slice at zero wraps to all ones.
    function automatic logic [W-1:0] f_apply_borrow(input logic [W-1:0]      v,
                                                     input logic [NSLICE-1:0] b);
        logic [W-1:0] res;
        res = v;
        for (int k = 0; k < NSLICE; k++) begin
            if (b[k]) begin
                res[k*SLICE_W +: SLICE_W] = v[k*SLICE_W +: SLICE_W] - SLICE_W'(1);
            end
        end
        return res;
    endfunction

    assign w_ready         = (r_state != S_RUN);
    assign ld_bus.ld_ready = w_ready;
    assign w_beat          = ld_bus.ld_valid & w_ready;

    // Lookahead: slice k borrows when enabled and every lower slice is zero.
    always_comb begin : borrow_lookahead
        logic b;
        b = 1'b0;
        for (int k = 0; k < NSLICE; k++) begin
            w_slice_zero[k] = (r_count[k*SLICE_W +: SLICE_W] == '0);
        end
        for (int k = 0; k < NSLICE; k++) begin
            b = i_cnt_en;
            for (int j = 0; j < k; j++) begin
                b = b & w_slice_zero[j];
            end
            w_borrow[k] = b;
        end
    end

    assign w_count_zero = &w_slice_zero;

    // Outside LOAD a beat always restarts the sequence at slice 0.
    always_comb begin
        w_wr_idx    = (r_state == S_LOAD) ? r_idx : '0;
        w_shadow_wr = r_shadow;
        w_shadow_wr[w_wr_idx*SLICE_W +: SLICE_W] = ld_bus.ld_data;
        w_last_beat = (w_wr_idx == LAST_IDX);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_shadow_nxt = r_shadow;
        w_idx_nxt    = r_idx;
        w_tc_nxt     = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (i_cnt_en) begin
                    if (w_count_zero) begin
                        w_tc_nxt = 1'b1;
                        if (i_auto_reload) begin
                            w_count_nxt = r_shadow;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_count_nxt = f_apply_borrow(r_count, w_borrow);
                    end
                end
                // A pause still lets this cycle's tc/reload action land.
                if (i_stop) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_IDLE, S_LOAD, S_ARM, S_DONE: begin
                if ((r_state == S_LOAD) && i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else if (w_beat) begin
                    w_shadow_nxt = w_shadow_wr;
                    if (w_last_beat) begin
                        w_count_nxt = w_shadow_wr;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_ARM;
                    end else begin
                        w_idx_nxt   = w_wr_idx + IDX_W'(1);
                        w_state_nxt = S_LOAD;
                    end
                end else if (i_start && (r_state == S_ARM)) begin
                    w_state_nxt = S_RUN;
                end else if (i_start && (r_state == S_DONE)) begin
                    w_count_nxt = r_shadow;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_shadow <= '0;
            r_idx    <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_shadow <= w_shadow_nxt;
            r_idx    <= w_idx_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_busy  = (r_state == S_LOAD) || (r_state == S_RUN);
    assign o_state = r_state;
endmodule

// File: tb/tb_cascade_timer_ctrl.sv
// Bench for cascade_timer_ctrl: per-scenario tasks; run phases use a queue of
// per-cycle stimulus plus expected count/tc/state.
module tb_cascade_timer_ctrl;
    localparam int NSLICE  = 4;
    localparam int SLICE_W = 4;
    localparam int W       = NSLICE * SLICE_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, auto_reload = 1'b0, cnt_en = 1'b0;
    logic [W-1:0] count;
    logic         tc, busy;
    logic [2:0]   state;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        logic         en;
        logic         stp;
        logic [W-1:0] count;
        logic         tc;
        logic [2:0]   state;
        string        tag;
    } exp_t;

    exp_t sb[$];

    cascade_timer_ctrl_if #(.SLICE_W(SLICE_W)) ld_if ();

    cascade_timer_ctrl #(.NSLICE(NSLICE), .SLICE_W(SLICE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_bus       (ld_if.slave),
        .i_start      (start),
        .i_stop       (stop),
        .i_auto_reload(auto_reload),
        .i_cnt_en     (cnt_en),
        .o_count      (count),
        .o_tc         (tc),
        .o_busy       (busy),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [SLICE_W-1:0] d);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = d;
        tick();
        ld_if.ld_valid = 1'b0;
    endtask

    task automatic load_value(input logic [W-1:0] v);
        for (int k = 0; k < NSLICE; k++) beat(v[k*SLICE_W +: SLICE_W]);
    endtask

    task automatic push(input logic en, input logic stp, input logic [W-1:0] c,
                        input logic t, input logic [2:0] s, input string tag);
        exp_t e;
        e.en = en; e.stp = stp; e.count = c; e.tc = t; e.state = s; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({state, count, tc, busy, ld_if.ld_ready} !== {3'd0, 16'h0000, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_values: got state=%0d count=%h tc=%b busy=%b rdy=%b want 0/0000/0/0/1",
                     state, count, tc, busy, ld_if.ld_ready);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        start_pulse();
        n_checks++;
        if (state !== 3'd0) $display("FAIL idle_ignores_start: got state=%0d want 0", state);
        else n_pass++;
    endtask

    task automatic test_basic_count();
        beat(4'h3);
        n_checks++;
        if ({state, busy} !== {3'd1, 1'b1}) $display("FAIL load_busy: got state=%0d busy=%b want 1/1", state, busy);
        else n_pass++;
        beat(4'h0); beat(4'h0); beat(4'h0);
        n_checks++;
        if ({state, count} !== {3'd2, 16'h0003}) $display("FAIL basic_armed: got state=%0d count=%h want 2/0003", state, count);
        else n_pass++;
        start_pulse();
        n_checks++;
        if ({state, count, busy, ld_if.ld_ready} !== {3'd3, 16'h0003, 1'b1, 1'b0})
            $display("FAIL basic_run_entry: got state=%0d count=%h busy=%b rdy=%b want 3/0003/1/0",
                     state, count, busy, ld_if.ld_ready);
        else n_pass++;
        push(1, 0, 16'h0002, 0, 3'd3, "basic_c2");
        push(1, 0, 16'h0001, 0, 3'd3, "basic_c1");
        push(1, 0, 16'h0000, 0, 3'd3, "basic_c0");
        push(1, 0, 16'h0000, 1, 3'd4, "basic_tc");
        push(1, 0, 16'h0000, 0, 3'd4, "basic_done_hold");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        cnt_en = 1'b0; stop = 1'b0;
        start_pulse();
        n_checks++;
        if ({state, count} !== {3'd3, 16'h0003}) $display("FAIL done_restart_reload: got state=%0d count=%h want 3/0003", state, count);
        else n_pass++;
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_borrow();
        load_value(16'h0010);
        start_pulse();
        push(1, 0, 16'h000F, 0, 3'd3, "borrow_wrap");
        push(1, 0, 16'h000E, 0, 3'd3, "borrow_next");
        push(0, 1, 16'h000E, 0, 3'd2, "borrow_pause");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        cnt_en = 1'b0; stop = 1'b0;
    endtask

    task automatic test_auto_reload();
        load_value(16'h0002);
        auto_reload = 1'b1;
        start_pulse();
        for (int p = 0; p < 3; p++) begin
            push(1, 0, 16'h0001, 0, 3'd3, "reload_c1");
            push(1, 0, 16'h0000, 0, 3'd3, "reload_c0");
            push(1, 0, 16'h0002, 1, 3'd3, "reload_tc");
        end
        push(0, 1, 16'h0002, 0, 3'd2, "reload_pause");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        cnt_en = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_enable_pause();
        load_value(16'h0005);
        start_pulse();
        push(1, 0, 16'h0004, 0, 3'd3, "en_on1");
        push(0, 0, 16'h0004, 0, 3'd3, "en_off1");
        push(1, 0, 16'h0003, 0, 3'd3, "en_on2");
        push(0, 0, 16'h0003, 0, 3'd3, "en_off2");
        push(0, 1, 16'h0003, 0, 3'd2, "en_pause");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        cnt_en = 1'b0; stop = 1'b0;
        n_checks++;
        if (ld_if.ld_ready !== 1'b1) $display("FAIL pause_ready: got %b want 1", ld_if.ld_ready);
        else n_pass++;
        start_pulse();
        push(1, 0, 16'h0002, 0, 3'd3, "resume_dec");
        push(0, 1, 16'h0002, 0, 3'd2, "resume_pause");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        cnt_en = 1'b0; stop = 1'b0;
    endtask

    task automatic test_load_abort();
        start = 1'b1;
        beat(4'h1);
        start = 1'b0;
        n_checks++;
        if (state !== 3'd1) $display("FAIL beat_beats_start: got state=%0d want 1", state);
        else n_pass++;
        beat(4'h2);
        stop = 1'b1; tick(); stop = 1'b0;
        n_checks++;
        if ({state, count, ld_if.ld_ready} !== {3'd0, 16'h0002, 1'b1})
            $display("FAIL abort_idle: got state=%0d count=%h rdy=%b want 0/0002/1", state, count, ld_if.ld_ready);
        else n_pass++;
        load_value(16'hABCD);
        n_checks++;
        if ({state, count} !== {3'd2, 16'hABCD}) $display("FAIL full_load: got state=%0d count=%h want 2/abcd", state, count);
        else n_pass++;
    endtask

    task automatic test_stop_at_tc();
        load_value(16'h0001);
        start_pulse();
        push(1, 0, 16'h0000, 0, 3'd3, "stoptc_c0");
        push(1, 1, 16'h0000, 1, 3'd2, "stoptc_arm");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        cnt_en = 1'b0; stop = 1'b0;
    endtask

    task automatic test_zero_load_reset();
        load_value(16'h0000);
        auto_reload = 1'b1;
        start_pulse();
        push(1, 0, 16'h0000, 1, 3'd3, "zero_tc1");
        push(1, 0, 16'h0000, 1, 3'd3, "zero_tc2");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tc, state, busy} !== {1'b0, 3'd0, 1'b0}) $display("FAIL async_reset_tc: got tc=%b state=%0d busy=%b want 0/0/0", tc, state, busy);
        else n_pass++;
        cnt_en = 1'b0; auto_reload = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_midrun();
        load_value(16'h0100);
        start_pulse();
        push(1, 0, 16'h00FF, 0, 3'd3, "mid_c1");
        push(1, 0, 16'h00FE, 0, 3'd3, "mid_c2");
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cnt_en = e.en; stop = e.stp;
            tick();
            n_checks++;
            if ({count, tc, state} !== {e.count, e.tc, e.state})
                $display("FAIL %s: got count=%h tc=%b state=%0d want count=%h tc=%b state=%0d",
                         e.tag, count, tc, state, e.count, e.tc, e.state);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({count, state, tc, ld_if.ld_ready} !== {16'h0000, 3'd0, 1'b0, 1'b1})
            $display("FAIL async_reset_run: got count=%h state=%0d tc=%b rdy=%b want 0000/0/0/1",
                     count, state, tc, ld_if.ld_ready);
        else n_pass++;
        cnt_en = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        start_pulse();
        n_checks++;
        if ({state, count} !== {3'd0, 16'h0000}) $display("FAIL post_reset_idle: got state=%0d count=%h want 0/0000", state, count);
        else n_pass++;
    endtask

    initial begin
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_count();
        test_borrow();
        test_auto_reload();
        test_enable_pause();
        test_load_abort();
        test_stop_at_tc();
        test_zero_load_reset();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
